uart_cmd_initiator: RTL
=======================

// Module: uart_cmd_initiator
// PURPOSE
//  Host-side initiator of the UART ALU command protocol; drives the same byte streams the ALU responder consumes.
//  Frames a command as opcode, reserved 0x00, len LSB, len MSB, then len payload bytes, onto a byte stream.
//  Collects the 4-byte big-endian result (with timeout) and returns it on a response handshake.
//  Sits between an on-chip master/test sequencer and a UART TX/RX byte-stream pair.
// PARAMETERS
//  datawidth_p      8      byte width of tx/rx/payload streams (protocol assumes 8)
//  timeout_cycles_p 1024   max idle cycles between response bytes before abort (>=2)
// PORTS
//  clk_i            in   1    clock
//  rst_i            in   1    reset, asynchronous, active-high
//  cmd_valid_i      in   1    command request valid
//  cmd_ready_o      out  1    command accepted when valid&ready
//  cmd_opcode_i     in   8    opcode (0x10 add, 0x11 mul, 0x12 div)
//  cmd_len_i        in   16   payload byte count, sent verbatim in header
//  payload_data_i   in   8    payload byte
//  payload_valid_i  in   1    payload byte valid
//  payload_ready_o  out  1    payload byte consumed when valid&ready
//  tx_data_o        out  8    byte to UART transmitter
//  tx_valid_o       out  1    tx byte valid
//  tx_ready_i       in   1    transmitter ready
//  rx_data_i        in   8    byte from UART receiver
//  rx_valid_i       in   1    rx byte valid
//  rx_ready_o       out  1    rx byte consumed when valid&ready
//  rsp_data_o       out  32   assembled result, first byte in [31:24]
//  rsp_timeout_o    out  1    response aborted by timeout
//  rsp_valid_o      out  1    response valid, held until rsp_ready_i
//  rsp_ready_i      in   1    response consumer ready
//  busy_o           out  1    high in every state except StIdle
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready_o=1 and rx_ready_o=1 (StIdle); counters cleared.
//  States: StIdle > StHdrOp > StHdrRsv > StHdrLenL > StHdrLenM > StPayload > StRsp > StDone > StIdle.
//  StIdle: cmd_ready_o=1; on cmd handshake latch opcode/len; rx bytes accepted and discarded.
//  tx output is a register; loads when !tx_valid_o || tx_ready_i; data/valid stable while stalled.
//  Latency: cmd handshake cycle N -> tx_valid_o=1 with opcode at N+1; 1 byte/cycle with tx_ready_i high.
//  Header bytes in order: opcode, 8'h00, len[7:0], len[15:8]; advance on each tx register load.
//  StPayload: payload_ready_o = (!tx_valid_o || tx_ready_i); forward exactly len bytes; len=0 skips state.
//  len=16'hFFFF forwards 65535 bytes; 16-bit down-counter, no wrap.
//  StRsp entered when last header/payload byte is accepted by transmitter (tx handshake), not on load.
//  StRsp: rx_ready_o=1; 2-bit byte index; byte k goes to rsp_data[31-8k -: 8]; 4th byte -> StDone, timeout=0.
//  Timeout: counter clears on entering StRsp and on each rx handshake; reaching timeout_cycles_p-1 -> StDone,
//    rsp_timeout_o=1, unreceived bytes read 0.
//  Simultaneous 4th rx byte and timeout expiry: byte wins, rsp_timeout_o=0.
//  StDone: rsp_valid_o=1, rx_ready_o=0, data stable; rsp handshake -> StIdle; next cmd accepted one cycle later.
//  cmd_ready_o and payload_ready_o never high in same cycle; payload bytes outside StPayload not consumed.
//  Reset mid-operation: immediate return to StIdle, partial frame abandoned, no response emitted.
// CONFIGURATION
//  UART_CMD_INITIATOR_STATS_EN defined: adds outputs stat_cmd_o[15:0] (commands completed),
//    stat_timeout_o[15:0] (timeout responses), stat_drop_o[15:0] (rx bytes discarded in StIdle);
//    saturating, increment on rsp handshake / timeout entry / discard; cleared by reset.
//  Not defined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  uart_pkg: OP_ADD/OP_MUL/OP_DIV opcodes, RSV_BYTE=8'h00, HDR_BYTES=4, RSP_BYTES=4, initiator state enum.
//  Sub-module uart_rsp_collector: byte index, 32-bit assembly, timeout counter; emits done/timeout.
// TESTING
//  1 opcode 0x10, len 0, tx_ready_i=1; rx 00 00 01 2C -> tx 10 00 00 00; rsp 0x0000012C, timeout 0.
//  2 opcode 0x11, len 3, payload AA BB CC, tx_ready_i toggling -> tx 11 00 03 00 AA BB CC, stable when stalled.
//  3 timeout_cycles_p=16; rx DE AD then silence -> 16 cycles later rsp 0xDEAD0000, rsp_timeout_o=1.
//  4 rst_i asserted mid-payload -> outputs at reset values same cycle; next cmd restarts at header opcode.
//  5 rsp_ready_i low 10 cycles -> rsp stable, cmd_ready_o=0, rx_ready_o=0; stray rx byte unconsumed.
//  6 STATS_EN: 2 rx bytes while idle, 3 cmds with 1 timeout -> stat_drop 2, stat_cmd 3, stat_timeout 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared opcodes, protocol byte counts and the initiator state encoding
// for the UART ALU command protocol.
package uart_pkg;

   localparam logic [7:0] OP_ADD   = 8'h10;
   localparam logic [7:0] OP_MUL   = 8'h11;
   localparam logic [7:0] OP_DIV   = 8'h12;
   localparam logic [7:0] RSV_BYTE = 8'h00;
   localparam int         HDR_BYTES = 4;
   localparam int         RSP_BYTES = 4;

   typedef enum logic [2:0] {
      StIdle,
      StHdrOp,
      StHdrRsv,
      StHdrLenL,
      StHdrLenM,
      StPayload,
      StRsp,
      StDone
   } init_state_e;

   // Response byte k lands in the most-significant free lane (big-endian).
   function automatic int rsp_lane_lsb(input logic [1:0] idx, input int dw);
      return (RSP_BYTES - 1 - int'(idx)) * dw;
   endfunction

endpackage

// File: rtl/uart_rsp_collector.sv
// Assembles the 4-byte big-endian response and aborts after timeout_cycles_p
// idle cycles between bytes; done/timeout are single-cycle combinational strobes.
module uart_rsp_collector
   import uart_pkg::*;
#(
   parameter int datawidth_p      = 8,
   parameter int timeout_cycles_p = 1024
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             start_i,
   input  logic                             active_i,
   input  logic                             rx_hs_i,
   input  logic [datawidth_p-1:0]           rx_data_i,
   output logic                             done_o,
   output logic                             timeout_o,
   output logic [RSP_BYTES*datawidth_p-1:0] data_o
);

   localparam int CntW = (timeout_cycles_p > 2) ? $clog2(timeout_cycles_p) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(timeout_cycles_p - 1);

   logic [1:0]                       r_idx;
   logic [CntW-1:0]                  r_cnt;
   logic [RSP_BYTES*datawidth_p-1:0] r_data;

   // A byte arriving on the expiry cycle suppresses the timeout.
   assign done_o    = active_i && rx_hs_i && (r_idx == 2'd3);
   assign timeout_o = active_i && !rx_hs_i && (r_cnt == CntLast);
   assign data_o    = r_data;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_idx  <= '0;
         r_cnt  <= '0;
         r_data <= '0;
      end else if (start_i) begin
         r_idx  <= '0;
         r_cnt  <= '0;
         r_data <= '0;
      end else if (active_i) begin
         if (rx_hs_i) begin
            r_data[rsp_lane_lsb(r_idx, datawidth_p) +: datawidth_p] <= rx_data_i;
            r_idx <= r_idx + 2'd1;
            r_cnt <= '0;
         end else if (r_cnt != CntLast) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_cmd_initiator.sv
// Frames opcode/rsv/len/payload onto the tx byte stream, then collects a 4-byte result.
// Optional UART_CMD_INITIATOR_STATS_EN adds saturating command/timeout/drop counters.
module uart_cmd_initiator
   import uart_pkg::*;
#(
   parameter int datawidth_p      = 8,
   parameter int timeout_cycles_p = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic [7:0]             cmd_opcode_i,
   input  logic [15:0]            cmd_len_i,
   input  logic [datawidth_p-1:0] payload_data_i,
   input  logic                   payload_valid_i,
   output logic                   payload_ready_o,
   output logic [datawidth_p-1:0] tx_data_o,
   output logic                   tx_valid_o,
   input  logic                   tx_ready_i,
   input  logic [datawidth_p-1:0] rx_data_i,
   input  logic                   rx_valid_i,
   output logic                   rx_ready_o,
   output logic [31:0]            rsp_data_o,
   output logic                   rsp_timeout_o,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic                   busy_o
`ifdef UART_CMD_INITIATOR_STATS_EN
   ,
   output logic [15:0]            stat_cmd_o,
   output logic [15:0]            stat_timeout_o,
   output logic [15:0]            stat_drop_o
`endif
);

   init_state_e            r_state;
   logic [15:0]            r_len;
   logic [15:0]            r_cnt;
   logic [datawidth_p-1:0] r_tx_data;
   logic                   r_tx_vld;
   logic                   r_rsp_tmo;

   logic w_can_load;
   logic w_tx_hs;
   logic w_pay_rdy;
   logic w_in_rsp;
   logic w_rx_hs_rsp;
   logic w_rsp_start;
   logic w_col_done;
   logic w_col_tmo;
   logic [RSP_BYTES*datawidth_p-1:0] w_rsp_data;

   assign w_can_load  = !r_tx_vld || tx_ready_i;
   assign w_tx_hs     = r_tx_vld && tx_ready_i;
   assign w_in_rsp    = (r_state == StRsp);
   assign w_rx_hs_rsp = rx_valid_i && w_in_rsp;
   // r_cnt counts payload bytes still to load; zero means only the final handshake is pending.
   assign w_pay_rdy   = (r_state == StPayload) && (r_cnt != 16'd0) && w_can_load;
   assign w_rsp_start = w_tx_hs && ((r_state == StHdrLenM) ||
                                    ((r_state == StPayload) && (r_cnt == 16'd0)));

   assign cmd_ready_o     = (r_state == StIdle);
   assign payload_ready_o = w_pay_rdy;
   assign tx_data_o       = r_tx_data;
   assign tx_valid_o      = r_tx_vld;
   assign rx_ready_o      = (r_state == StIdle) || w_in_rsp;
   assign rsp_data_o      = w_rsp_data;
   assign rsp_timeout_o   = r_rsp_tmo;
   assign rsp_valid_o     = (r_state == StDone);
   assign busy_o          = (r_state != StIdle);

   uart_rsp_collector #(
      .datawidth_p      (datawidth_p),
      .timeout_cycles_p (timeout_cycles_p)
   ) u_collector (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (w_rsp_start),
      .active_i  (w_in_rsp),
      .rx_hs_i   (w_rx_hs_rsp),
      .rx_data_i (rx_data_i),
      .done_o    (w_col_done),
      .timeout_o (w_col_tmo),
      .data_o    (w_rsp_data)
   );

   // State names the header byte currently held in the tx register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= StIdle;
         r_len     <= '0;
         r_cnt     <= '0;
         r_tx_data <= '0;
         r_tx_vld  <= 1'b0;
         r_rsp_tmo <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (cmd_valid_i) begin
                  r_len     <= cmd_len_i;
                  r_cnt     <= cmd_len_i;
                  r_tx_data <= cmd_opcode_i;
                  r_tx_vld  <= 1'b1;
                  r_state   <= StHdrOp;
               end
            end
            StHdrOp: begin
               if (w_can_load) begin
                  r_tx_data <= RSV_BYTE;
                  r_tx_vld  <= 1'b1;
                  r_state   <= StHdrRsv;
               end
            end
            StHdrRsv: begin
               if (w_can_load) begin
                  r_tx_data <= r_len[7:0];
                  r_tx_vld  <= 1'b1;
                  r_state   <= StHdrLenL;
               end
            end
            StHdrLenL: begin
               if (w_can_load) begin
                  r_tx_data <= r_len[15:8];
                  r_tx_vld  <= 1'b1;
                  r_state   <= (r_len == 16'd0) ? StHdrLenM : StPayload;
               end
            end
            StHdrLenM: begin
               if (w_tx_hs) begin
                  r_tx_vld <= 1'b0;
                  r_state  <= StRsp;
               end
            end
            StPayload: begin
               if (r_cnt != 16'd0) begin
                  if (w_can_load) begin
                     r_tx_vld <= payload_valid_i;
                     if (payload_valid_i) begin
                        r_tx_data <= payload_data_i;
                        r_cnt     <= r_cnt - 16'd1;
                     end
                  end
               end else if (w_tx_hs) begin
                  r_tx_vld <= 1'b0;
                  r_state  <= StRsp;
               end
            end
            StRsp: begin
               if (w_col_done) begin
                  r_rsp_tmo <= 1'b0;
                  r_state   <= StDone;
               end else if (w_col_tmo) begin
                  r_rsp_tmo <= 1'b1;
                  r_state   <= StDone;
               end
            end
            StDone: begin
               if (rsp_ready_i) begin
                  r_rsp_tmo <= 1'b0;
                  r_state   <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

`ifdef UART_CMD_INITIATOR_STATS_EN
   logic [15:0] r_stat_cmd;
   logic [15:0] r_stat_tmo;
   logic [15:0] r_stat_drop;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stat_cmd  <= '0;
         r_stat_tmo  <= '0;
         r_stat_drop <= '0;
      end else begin
         if ((r_state == StDone) && rsp_ready_i && (r_stat_cmd != 16'hFFFF))
            r_stat_cmd <= r_stat_cmd + 16'd1;
         if (w_col_tmo && (r_stat_tmo != 16'hFFFF))
            r_stat_tmo <= r_stat_tmo + 16'd1;
         if ((r_state == StIdle) && rx_valid_i && (r_stat_drop != 16'hFFFF))
            r_stat_drop <= r_stat_drop + 16'd1;
      end
   end

   assign stat_cmd_o     = r_stat_cmd;
   assign stat_timeout_o = r_stat_tmo;
   assign stat_drop_o    = r_stat_drop;
`endif

endmodule
